fsm_trace_checker: RTL and testbench
====================================

Name: fsm_trace_checker

Overview:
- Reader side of the 2-bit state-encoding trace that our FSM test designs emit (current_state sampled each clk).
- Consumes the trace over a valid strobe and checks every step against the fixed legal transition table S1->S2, S2->S1, S3->S1, with self-loops allowed.
- Flags illegal transitions and the illegal encoding 2'b11, keeps per-state visit counts, and at the end of each window reports which legal states were never reached.
- Sits beside the FSM under test in lint regression benches as a synthesizable, clean reference design.

Parameters:
- WINDOW, default 16: number of valid samples per observation window; must be >= 2.
- CNT_W, default 8: width of each per-state visit counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; opens a new window.
- abort  input  1  one-cycle pulse; discards the current window and returns to IDLE.
- trace_valid  input  1  trace_in is meaningful this cycle.
- trace_in  input  2  state encoding: S1=2'b00, S2=2'b01, S3=2'b10, 2'b11 illegal.
- busy  output  1  high in FIRST and TRACK.
- illegal_trans  output  1  one-cycle pulse: the previous->current step is not in the legal table.
- illegal_code  output  1  one-cycle pulse: trace_in==2'b11 was accepted.
- report_valid  output  1  one-cycle pulse at end of window.
- unreached_mask  output  3  bit i set = legal state Si+1 never seen in window; valid with report_valid, held until the next report.
- cnt_s1, cnt_s2, cnt_s3  output  CNT_W each  visit counts for the current window; held after the report.

Behaviour:
- Reset (synchronous, active-high) drives: state=IDLE, busy=0, illegal_trans=0, illegal_code=0, report_valid=0, unreached_mask=3'b000, all counters=0, prev register=S1, sample count=0. Reset has priority over every other input, including mid-window.
- FSM states: IDLE, FIRST, TRACK, REPORT.
- IDLE: trace_valid is ignored. start goes to FIRST; on that same edge the counters, visited flags and sample count are cleared.
- FIRST: the first valid sample loads prev, sets its visited flag, increments its counter and sets sample count=1. No transition check is made for this sample. Next state is TRACK.
- TRACK: each valid sample is checked against prev.
  - The illegal_trans / illegal_code pulses assert on the edge after the sample is accepted (latency 1).
  - An illegal code does not update prev, visited or any counter, but it does count toward WINDOW.
  - A transition out of an illegal code cannot occur, because prev only ever holds legal codes.
  - When sample count reaches WINDOW, go to REPORT.
- REPORT: held for 1 cycle.
  - report_valid=1 and unreached_mask=~visited[2:0] are registered together.
  - Next state is IDLE, or FIRST if start is high in this cycle (back-to-back windows).
- start while in FIRST or TRACK restarts the window: the FIRST clear rules apply and no report is produced.
- abort in any non-IDLE state goes to IDLE. Counters and unreached_mask hold their values. If start and abort arrive together, abort wins.
- Counters saturate at their maximum value and never wrap.
- trace_valid=0 cycles are stalls: no state change other than the start/abort/rst effects above.
- busy is a registered decode of state (FIRST|TRACK).

Decomposition:
- Package fsm_trace_pkg holds:
  - state encodings S1/S2/S3/S_ILL;
  - checker FSM state constants;
  - function legal_step(prev, cur) implementing the transition table (self-loops legal).
- Sub-module sat_counter (parameter W; ports clk, rst, clr, inc, q) is instantiated three times for the visit counters.

Test Plan:
- Reset mid-window: start, feed 5 samples, assert rst -> next cycle busy=0, cnt_s1=cnt_s2=cnt_s3=0, no report_valid.
- WINDOW=4 legal trace 00,01,00,01 -> no illegal pulses; report_valid one cycle after the 4th sample; unreached_mask=3'b100; cnt_s1=2, cnt_s2=2.
- Trace 00,10 -> illegal_trans pulses one cycle after the 10 sample (S1->S3 is illegal); cnt_s3=1.
- Trace 01,11,00 -> illegal_code pulses once and there is no illegal_trans; the 01->00 check uses prev=01 and is legal; cnt_s1 and cnt_s2 each increment once.
- CNT_W=2, WINDOW=8, all samples 00 -> cnt_s1 saturates at 3; unreached_mask=3'b110.
- start asserted in the REPORT cycle -> report_valid=1 and busy=1 on the next cycle; a new window begins with counters cleared; a later abort leaves the counters at their held values.

Source files
------------

// File: rtl/fsm_trace_pkg.sv
// Shared encodings and the legal transition table for the FSM trace checker.
//   code_t      : 2-bit trace encodings S1/S2/S3 plus the illegal code
//   chk_state_t : checker FSM states
//   legal_step  : 1 when prev->cur is an allowed step (self-loops included)
package fsm_trace_pkg;

    typedef enum logic [1:0] {
        S1    = 2'b00,
        S2    = 2'b01,
        S3    = 2'b10,
        S_ILL = 2'b11
    } code_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FIRST  = 2'b01,
        ST_TRACK  = 2'b10,
        ST_REPORT = 2'b11
    } chk_state_t;

    // Allowed steps: S1->S2, S2->S1, S3->S1 and any self-loop.
    function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
        logic ok;
        ok = (prev == cur)
          || (prev == S1 && cur == S2)
          || (prev == S2 && cur == S1)
          || (prev == S3 && cur == S1);
        return ok;
    endfunction

endpackage

// File: rtl/fsm_trace_checker_sat_counter.sv
// Saturating up-counter used for per-state visit counts.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear
//   inc      : increment request, ignored once at all-ones
//   q        : current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/fsm_trace_checker.sv
// Checks a 2-bit FSM state trace against the legal transition table,
// flags illegal steps/codes, counts visits and reports unreached states
// at the end of each WINDOW-sample observation window.
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : open a new window / discard the current one
//   trace_valid,trace_in: trace sample strobe and state encoding
//   busy                : window in progress (FIRST or TRACK)
//   illegal_trans/code  : one-cycle pulses, one cycle after the sample
//   report_valid        : one-cycle end-of-window pulse
//   unreached_mask      : bit i = state S(i+1) not seen, held to next report
//   cnt_s1..cnt_s3      : saturating visit counts of the current window
module fsm_trace_checker
    import fsm_trace_pkg::*;
#(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             trace_valid,
    input  logic [1:0]       trace_in,
    output logic             busy,
    output logic             illegal_trans,
    output logic             illegal_code,
    output logic             report_valid,
    output logic [2:0]       unreached_mask,
    output logic [CNT_W-1:0] cnt_s1,
    output logic [CNT_W-1:0] cnt_s2,
    output logic [CNT_W-1:0] cnt_s3
);

    localparam int unsigned SC_W = $clog2(WINDOW + 1);

    chk_state_t      state, state_d;
    logic [1:0]      prev, prev_d;
    logic [2:0]      visited, visited_d;
    logic [SC_W-1:0] smp_cnt, smp_cnt_d;
    logic            busy_d, itrans_d, icode_d, rv_d;
    logic [2:0]      mask_d;
    logic            clr_c;
    logic [2:0]      inc_c;
    logic [2:0]      hot_c;
    logic [SC_W-1:0] cnt_nx_c;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            prev           <= S1;
            visited        <= 3'b000;
            smp_cnt        <= '0;
            busy           <= 1'b0;
            illegal_trans  <= 1'b0;
            illegal_code   <= 1'b0;
            report_valid   <= 1'b0;
            unreached_mask <= 3'b000;
        end else begin
            state          <= state_d;
            prev           <= prev_d;
            visited        <= visited_d;
            smp_cnt        <= smp_cnt_d;
            busy           <= busy_d;
            illegal_trans  <= itrans_d;
            illegal_code   <= icode_d;
            report_valid   <= rv_d;
            unreached_mask <= mask_d;
        end
    end

    // Next-state, sample acceptance and output decode.
    always_comb begin
        state_d   = state;
        prev_d    = prev;
        visited_d = visited;
        smp_cnt_d = smp_cnt;
        clr_c     = 1'b0;
        inc_c     = 3'b000;
        itrans_d  = 1'b0;
        icode_d   = 1'b0;
        hot_c     = 3'b001 << trace_in;
        cnt_nx_c  = smp_cnt + SC_W'(1);

        // The report is taken from the REPORT cycle itself, so a start or
        // abort arriving in that cycle does not suppress it.
        rv_d   = (state == ST_REPORT);
        mask_d = (state == ST_REPORT) ? ~visited : unreached_mask;

        if (abort) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d   = ST_FIRST;
            clr_c     = 1'b1;
            visited_d = 3'b000;
            smp_cnt_d = '0;
        end else begin
            case (state)
                ST_FIRST, ST_TRACK: begin
                    if (trace_valid) begin
                        smp_cnt_d = cnt_nx_c;
                        if (trace_in == S_ILL) begin
                            // Illegal code counts toward the window only;
                            // prev stays on the last legal code.
                            icode_d = 1'b1;
                        end else begin
                            itrans_d  = (state == ST_TRACK) && !legal_step(prev, trace_in);
                            prev_d    = trace_in;
                            visited_d = visited | hot_c;
                            inc_c     = hot_c;
                            state_d   = ST_TRACK;
                        end
                        if (cnt_nx_c == SC_W'(WINDOW)) begin
                            state_d = ST_REPORT;
                        end
                    end
                end
                ST_REPORT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_FIRST) || (state_d == ST_TRACK);
    end

    sat_counter #(.W(CNT_W)) u_cnt_s1 (.clk(clk), .rst(rst), .clr(clr_c), .inc(inc_c[0]), .q(cnt_s1));
    sat_counter #(.W(CNT_W)) u_cnt_s2 (.clk(clk), .rst(rst), .clr(clr_c), .inc(inc_c[1]), .q(cnt_s2));
    sat_counter #(.W(CNT_W)) u_cnt_s3 (.clk(clk), .rst(rst), .clr(clr_c), .inc(inc_c[2]), .q(cnt_s3));

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Self-checking bench for fsm_trace_checker: directed scenarios followed by
// randomized traffic, all compared against a window-level reference model.
module tb_fsm_trace_checker;

    localparam int unsigned WINDOW = 8;
    localparam int unsigned CNT_W  = 2;
    localparam int          CMAX   = 3;

    localparam int M_IDLE = 0;
    localparam int M_COLL = 1;
    localparam int M_REP  = 2;

    logic             clk = 1'b0;
    logic             rst, start, abort, trace_valid;
    logic [1:0]       trace_in;
    logic             busy, illegal_trans, illegal_code, report_valid;
    logic [2:0]       unreached_mask;
    logic [CNT_W-1:0] cnt_s1, cnt_s2, cnt_s3;

    fsm_trace_checker #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .trace_valid(trace_valid), .trace_in(trace_in),
        .busy(busy), .illegal_trans(illegal_trans), .illegal_code(illegal_code),
        .report_valid(report_valid), .unreached_mask(unreached_mask),
        .cnt_s1(cnt_s1), .cnt_s2(cnt_s2), .cnt_s3(cnt_s3)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: window bookkeeping in plain integers.
    int   m_mode;
    int   m_nsamp;
    bit   m_have_prev;
    int   m_prev;
    int   m_cnt [3];
    bit   m_seen[3];
    bit   allowed[4][4];
    bit   e_it, e_ic, e_rv;
    logic [2:0] e_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_nsamp = 0; m_have_prev = 0; m_prev = 0;
        for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_seen[i] = 0; end
        e_it = 0; e_ic = 0; e_rv = 0; e_mask = 3'b000;
    endtask

    task automatic model_step(input bit r, input bit s, input bit a, input bit v, input int c);
        e_it = 0; e_ic = 0; e_rv = 0;
        if (r) begin
            model_reset();
        end else begin
            if (m_mode == M_REP) begin
                e_rv = 1;
                for (int i = 0; i < 3; i++) e_mask[i] = !m_seen[i];
            end
            if (a) begin
                m_mode = M_IDLE;
            end else if (s) begin
                m_mode = M_COLL; m_nsamp = 0; m_have_prev = 0;
                for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_seen[i] = 0; end
            end else if (m_mode == M_COLL) begin
                if (v) begin
                    m_nsamp++;
                    if (c == 3) begin
                        e_ic = 1;
                    end else begin
                        if (m_have_prev && !allowed[m_prev][c]) e_it = 1;
                        m_prev = c; m_have_prev = 1; m_seen[c] = 1;
                        if (m_cnt[c] < CMAX) m_cnt[c]++;
                    end
                    if (m_nsamp == WINDOW) m_mode = M_REP;
                end
            end else if (m_mode == M_REP) begin
                m_mode = M_IDLE;
            end
        end
    endtask

    task automatic compare_all();
        check("busy",    32'(busy),           32'(m_mode == M_COLL));
        check("itrans",  32'(illegal_trans),  32'(e_it));
        check("icode",   32'(illegal_code),   32'(e_ic));
        check("rvalid",  32'(report_valid),   32'(e_rv));
        check("mask",    32'(unreached_mask), 32'(e_mask));
        check("cnt_s1",  32'(cnt_s1),         32'(m_cnt[0]));
        check("cnt_s2",  32'(cnt_s2),         32'(m_cnt[1]));
        check("cnt_s3",  32'(cnt_s3),         32'(m_cnt[2]));
    endtask

    // Drive one cycle of inputs, then compare outputs after the edge.
    task automatic cycle(input bit r, input bit s, input bit a, input bit v, input int c);
        rst = r; start = s; abort = a; trace_valid = v; trace_in = 2'(c);
        @(posedge clk);
        #1;
        model_step(r, s, a, v, c);
        compare_all();
    endtask

    task automatic sample(input int c);
        cycle(0, 0, 0, 1, c);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int p = 0; p < 4; p++)
            for (int q = 0; q < 4; q++)
                allowed[p][q] = (p == q) && (p != 3);
        allowed[0][1] = 1;
        allowed[1][0] = 1;
        allowed[2][0] = 1;
        model_reset();
        rst = 1; start = 0; abort = 0; trace_valid = 0; trace_in = 2'b00;

        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        idle();

        // Reset in the middle of a window.
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) sample(i % 2);
        cycle(1, 0, 0, 0, 0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_cnt1", 32'(cnt_s1), 32'd0);
        idle();

        // Legal alternating S1/S2 window: S3 unreached, counters saturate.
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < WINDOW; i++) sample(i % 2);
        idle();
        check("legal_rv",   32'(report_valid),   32'd1);
        check("legal_mask", 32'(unreached_mask), 32'b100);
        idle();

        // S1 -> S3 is illegal.
        cycle(0, 1, 0, 0, 0);
        sample(0);
        sample(2);
        check("s1s3_itrans", 32'(illegal_trans), 32'd1);
        check("s1s3_cnt3",   32'(cnt_s3),        32'd1);
        cycle(0, 0, 1, 0, 0);

        // Illegal code between S2 and S1: only illegal_code fires.
        cycle(0, 1, 0, 0, 0);
        sample(1);
        sample(3);
        check("ill_code", 32'(illegal_code), 32'd1);
        sample(0);
        check("ill_no_trans", 32'(illegal_trans), 32'd0);
        cycle(0, 0, 1, 0, 0);

        // All S1 with a stall in the middle: saturation and mask 110.
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < WINDOW; i++) begin
            sample(0);
            if (i == 3) idle();
        end
        idle();
        check("sat_cnt1", 32'(cnt_s1),         32'd3);
        check("sat_mask", 32'(unreached_mask), 32'b110);

        // Start in the REPORT cycle, then abort holds counters.
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < WINDOW; i++) sample(2 - 2 * (i % 2));
        cycle(0, 1, 0, 0, 0);
        check("b2b_rv",   32'(report_valid), 32'd1);
        check("b2b_busy", 32'(busy),         32'd1);
        check("b2b_clr",  32'(cnt_s3),       32'd0);
        sample(1);
        sample(1);
        cycle(0, 0, 1, 0, 0);
        check("abort_hold", 32'(cnt_s2), 32'd2);
        idle();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            bit r, s, a, v;
            int c;
            r = ($urandom_range(0, 499) == 0);
            s = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
            cycle(r, s, a, v, c);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
